// File: rtl/seq_detect_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_detect_param : KMP-table serial pattern detector with saturating counter
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b10010,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clear_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int              c_sw    = $clog2(N + 1);
  localparam int              c_depth = 2 ** c_sw;
  localparam logic [c_sw-1:0] c_last  = c_sw'(N - 1);

  function automatic bit pat_bit(input int i);
    logic [N-1:0] sh;
    sh = PATTERN >> i;
    return sh[0];
  endfunction

  // Longest proper prefix (length < N) that is a suffix of prefix(s) followed
  // by b. For s = N-1 and b = PATTERN[0] this is the full-pattern failure length.
  function automatic int kmp_next(input int s, input int b);
    int best;
    int m;
    bit ok;
    bit cand;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          m    = s + 1 - k + j;
          cand = (m < s) ? pat_bit(N - 1 - m) : (b != 0);
          if (pat_bit(N - 1 - j) != cand) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  logic [c_sw-1:0] nxt0 [c_depth];
  logic [c_sw-1:0] nxt1 [c_depth];

  generate
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_tab
      if (gi < N) begin : g_live
        localparam logic [c_sw-1:0] c_nxt0 = c_sw'(kmp_next(gi, 0));
        localparam logic [c_sw-1:0] c_nxt1 = c_sw'(kmp_next(gi, 1));
        assign nxt0[gi] = c_nxt0;
        assign nxt1[gi] = c_nxt1;
      end else begin : g_pad
        assign nxt0[gi] = '0;
        assign nxt1[gi] = '0;
      end
    end
  endgenerate

  logic [c_sw-1:0]  s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit       = en & (s_q == c_last) & (x == PATTERN[0]);
  assign cnt_sat   = &cnt_q;
  assign match_cnt = cnt_q;

  always_comb begin
    s_d = s_q;
    if (en) begin
      if (hit && !OVERLAP) s_d = '0;
      else                 s_d = x ? nxt1[s_q] : nxt0[s_q];
    end
    // Clear takes priority over a coincident match.
    cnt_d = cnt_q;
    if (clear_cnt)              cnt_d = '0;
    else if (hit && !cnt_sat)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic z_q, z_d;
      assign z_d = hit;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) z_q <= 1'b0;
        else     z_q <= z_d;
      end
      assign z = z_q;
    end else begin : g_mealy
      assign z = hit;
    end
  endgenerate

endmodule
`default_nettype wire
